bin2bcd_seq: RTL and testbench

Sequential binary-to-packed-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It feeds the 16-bit `in_port` of the BCD readback PIO (`bcd1`) with a stable 4-digit packed BCD value. It also supplies the same value to the display path. The converter holds its last result between conversions, so the Avalon read side always samples a settled value.

---
 rtl/bin2bcd_seq.sv | 146 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary -> packed BCD converter (shift-and-add-3, one input bit
//   per clock). Holds its last result between conversions so a bus reader
//   always samples a settled value.
//
// Parameters
//   BIN_W    number of significant bin_in bits converted (4..16).
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   conversion request, honoured only while idle
//   bin_in   in   [15:0] unsigned value, latched when start is accepted
//   busy     out  high while a conversion is in flight
//   done     out  one-cycle pulse when bcd_out/ovf have just been updated
//   bcd_out  out  [15:0] packed BCD, digit 3 in [15:12] .. digit 0 in [3:0]
//   ovf      out  last converted value exceeded 9999
//
// Build option
//   BIN2BCD_SATURATE_EN  when defined, an overflowing result reads 0x9999;
//                        otherwise the low four digits (value mod 10000).
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [4:0] CNT_INIT = 5'(BIN_W);

  state_t            state_q, state_d;
  logic [19:0]       acc_q,   acc_d;
  logic [BIN_W-1:0]  sr_q,    sr_d;
  logic [4:0]        cnt_q,   cnt_d;
  logic [15:0]       bcd_q,   bcd_d;
  logic              ovf_q,   ovf_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  // Accumulator after the add-3 correction, all five digits in parallel.
  logic [19:0]       acc_adj;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                     : acc_q[4*i +: 4];
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the
    // case statement leaves a signal unassigned (which would infer a latch).
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = bin_in[BIN_W-1:0];
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The top digit cannot carry out for BIN_W <= 16, so dropping the
        // MSB of the shifted word loses nothing.
        acc_d = 20'({acc_adj, sr_q[BIN_W-1]});
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ovf_d = (acc_q[19:16] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
        bcd_d = (acc_q[19:16] != 4'd0) ? 16'h9999 : acc_q[15:0];
`else
        bcd_d = acc_q[15:0];
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq (BIN_W = 16). Expected results come
//   from a decimal-arithmetic reference model; outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // done must never be high on two consecutive samples.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      total++;
      if (done_prev) begin
        bad++;
        $display("FAIL done_consecutive: done high two cycles in a row, required single pulse");
      end
    end
    done_prev <= done;
  end

  // Reference: decimal digits of v; overflow above 9999.
  function automatic logic [16:0] model(input int v);
    logic [15:0] b;
    b[3:0]   = 4'(v % 10);
    b[7:4]   = 4'((v / 10) % 10);
    b[11:8]  = 4'((v / 100) % 10);
    b[15:12] = 4'((v / 1000) % 10);
`ifdef BIN2BCD_SATURATE_EN
    if (v > 9999) b = 16'h9999;
`endif
    return {(v > 9999), b};
  endfunction

  function automatic bit digits_ok(input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Issue one start pulse with value v (accepted at edge E0), then follow
  // the conversion to done. lat = edges from E0 to done (-1 on timeout),
  // busy_n = sampled cycles with busy high.
  task automatic convert(input logic [15:0] v, output int lat, output int busy_n,
                         output logic [15:0] b, output logic o);
    lat = -1;
    busy_n = 0;
    b = 'x;
    o = 1'bx;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    for (int k = 0; k <= 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        b   = bcd_out;
        o   = ovf;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_value(input string name, input int v);
    int lat, bn;
    logic [15:0] b;
    logic o;
    logic [16:0] exp;
    exp = model(v);
    convert(16'(v), lat, bn, b, o);
    total++;
    if (lat !== LAT || b !== exp[15:0] || o !== exp[16] || !digits_ok(b)) begin
      bad++;
      $display("FAIL %s: in=%0d lat=%0d bcd=%h ovf=%b, required lat=%0d bcd=%h ovf=%b",
               name, v, lat, b, o, LAT, exp[15:0], exp[16]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bcd_out !== 16'h0000 || ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: bcd=%h ovf=%b done=%b busy=%b, required 0000/0/0/0",
               bcd_out, ovf, done, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_latency();
    int lat, bn;
    logic [15:0] b;
    logic o;
    convert(16'd0, lat, bn, b, o);
    total++;
    if (lat !== LAT || b !== 16'h0000 || o !== 1'b0) begin
      bad++;
      $display("FAIL zero_conv: lat=%0d bcd=%h ovf=%b, required lat=%0d bcd=0000 ovf=0",
               lat, b, o, LAT);
    end
    total++;
    if (bn !== LAT) begin
      bad++;
      $display("FAIL busy_width: busy cycles=%0d, required %0d", bn, LAT);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_known();
    check_value("max_4digit", 9999);
    check_value("val_1234", 1234);
    check_value("ovf_10000", 10000);
    check_value("ovf_65535", 65535);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) check_value("rand_in_range", int'($urandom_range(0, 9999)));
    for (int i = 0; i < 60; i++)  check_value("rand_any", int'($urandom_range(0, 65535)));
  endtask

  // Re-pulse start at E5 with another value and wiggle bin_in; only the
  // original conversion may complete.
  task automatic test_ignore_start();
    int n_done = 0;
    int at = -1;
    logic [15:0] b = '0;
    @(negedge clk);
    bin_in = 16'd1111;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'd5555;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd2222;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'd3333;
    for (int k = 6; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (at < 0) begin
          at = k;
          b  = bcd_out;
        end
      end
    end
    total++;
    if (n_done !== 1 || at !== LAT || b !== 16'h1111) begin
      bad++;
      $display("FAIL ignore_start: dones=%0d at=%0d bcd=%h, required 1 at %0d bcd=1111",
               n_done, at, b, LAT);
    end
  endtask

  task automatic test_abort();
    int n_done = 0;
    check_value("pre_abort", 4321);
    @(negedge clk);
    bin_in = 16'd5678;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (bcd_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: bcd=%h busy=%b done=%b ovf=%b, required 0000/0/0/0",
               bcd_out, busy, done, ovf);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    total++;
    if (n_done !== 0 || bcd_out !== 16'h0000) begin
      bad++;
      $display("FAIL abort_no_done: dones=%0d bcd=%h, required 0 and 0000", n_done, bcd_out);
    end
    check_value("post_abort", 777);
  endtask

  // start held high: conversions chain with period BIN_W+2.
  task automatic test_back_to_back();
    int t[2] = '{-1, -1};
    logic [15:0] v[2] = '{16'hxxxx, 16'hxxxx};
    int n = 0;
    int unstable = 0;
    logic [15:0] prev;
    @(negedge clk);
    bin_in = 16'd42;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bin_in = 16'd4321;
    prev   = bcd_out;
    for (int k = 0; k < 60 && n < 2; k++) begin
      if (done) begin
        t[n] = k;
        v[n] = bcd_out;
        n++;
        if (n == 2) start = 1'b0;
      end else if (bcd_out !== prev) begin
        unstable++;
      end
      prev = bcd_out;
      if (n < 2) @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (t[0] !== LAT || v[0] !== 16'h0042) begin
      bad++;
      $display("FAIL b2b_first: at=%0d bcd=%h, required at %0d bcd=0042", t[0], v[0], LAT);
    end
    total++;
    if (t[1] - t[0] !== BIN_W + 2 || v[1] !== 16'h4321) begin
      bad++;
      $display("FAIL b2b_second: spacing=%0d bcd=%h, required %0d bcd=4321",
               t[1] - t[0], v[1], BIN_W + 2);
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL b2b_stable: bcd_out changed %0d times outside done, required 0", unstable);
    end
    repeat (25) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_known();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
